png_filter_mode: RTL

Streaming PNG scanline filter with a selectable filter type, parametrised bytes-per-pixel and a single prior-row line buffer. It accepts raw image bytes one per cycle with valid/ready flow control. For each row it emits the PNG filter-type byte followed by the filtered bytes, ready for the deflate stage. It replaces the fixed-type, ping-pong-FIFO filter wrapper in the encoder front end.

---
 rtl/png_filter_mode_if.sv | 13 +
 rtl/png_filter_mode.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/png_filter_mode_if.sv
// Byte-stream handshake bundle for the PNG filter: raw bytes in, typed/filtered bytes out.
interface png_filter_mode_if;
  logic       val_i;
  logic       rdy_o;
  logic [7:0] dat_i;
  logic       val_o;
  logic       rdy_i;
  logic [7:0] dat_o;
  logic       lst_o;

  modport slave  (input val_i, dat_i, rdy_i, output rdy_o, val_o, dat_o, lst_o);
  modport master (output val_i, dat_i, rdy_i, input rdy_o, val_o, dat_o, lst_o);
endinterface

// File: rtl/png_filter_mode.sv
// Streaming PNG scanline filter: emits a filter-type byte per row, then x - pred for each raw byte.
module png_filter_mode #(
  parameter int BPP   = 3,
  parameter int W_MAX = 4096,
  parameter int W_WD  = 13,
  parameter int H_WD  = 13
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [W_WD-1:0]   cfg_w_i,
  input  logic [H_WD-1:0]   cfg_h_i,
  input  logic [2:0]        cfg_mode_i,
  input  logic              start_i,
  output logic              done_o,
  png_filter_mode_if.slave  io
);
  localparam int CW   = W_WD + 3;
  localparam int LB_D = W_MAX * BPP;
  localparam int AW   = (LB_D > 1) ? $clog2(LB_D) : 1;

  typedef enum logic [1:0] {IDLE, TYPE, DATA, DONE} state_t;
  state_t state;

  logic [CW-1:0]         nbytes, bcnt;
  logic [H_WD-1:0]       h_r, rcnt;
  logic [2:0]            mode;
  logic [7:0]            lbuf [LB_D];
  logic [BPP-1:0][7:0]   a_sr, c_sr;
  logic                  val_q, lst_q;
  logic [7:0]            dat_q;
  logic                  out_free, acc, last_b, row0, head;
  logic [7:0]            x, a, b, c, pred, filt;
  logic [8:0]            sum9;
  logic [9:0]            db, da, dc, pa, pb, pc;

  assign io.val_o = val_q;
  assign io.dat_o = dat_q;
  assign io.lst_o = lst_q;

  assign x        = io.dat_i;
  assign out_free = !val_q || io.rdy_i;
  assign io.rdy_o = (state == DATA) && out_free;
  assign acc      = io.val_i && io.rdy_o;
  assign last_b   = (bcnt == nbytes - CW'(1));
  assign row0     = (rcnt == '0);
  assign head     = (bcnt < CW'(BPP));

  // Row 0 has no valid prior row; the first pixel of a row has no left neighbour.
  assign b = row0 ? 8'd0 : lbuf[bcnt[AW-1:0]];
  assign a = head ? 8'd0 : a_sr[BPP-1];
  assign c = (head || row0) ? 8'd0 : c_sr[BPP-1];

  // Paeth distances in 10-bit two's complement, then magnitudes.
  assign db = {2'b0, b} - {2'b0, c};
  assign da = {2'b0, a} - {2'b0, c};
  assign dc = {2'b0, a} + {2'b0, b} - {1'b0, c, 1'b0};
  assign pa = db[9] ? -db : db;
  assign pb = da[9] ? -da : da;
  assign pc = dc[9] ? -dc : dc;
  assign sum9 = {1'b0, a} + {1'b0, b};

  always_comb begin
    pred = 8'd0;
    case (mode)
      3'd1: pred = a;
      3'd2: pred = b;
      3'd3: pred = sum9[8:1];
      3'd4: begin
        if (pa <= pb && pa <= pc) pred = a;
        else if (pb <= pc)        pred = b;
        else                      pred = c;
      end
      default: pred = 8'd0;
    endcase
  end
  assign filt = x - pred;

  // Prior-row buffer: read old value this cycle, overwrite with the raw byte.
  always_ff @(posedge clk) begin
    if (acc) lbuf[bcnt[AW-1:0]] <= x;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      nbytes <= '0;
      bcnt   <= '0;
      h_r    <= '0;
      rcnt   <= '0;
      mode   <= '0;
      a_sr   <= '0;
      c_sr   <= '0;
      val_q  <= 1'b0;
      dat_q  <= '0;
      lst_q  <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (val_q && io.rdy_i) val_q <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          nbytes <= CW'(cfg_w_i) * CW'(BPP);
          h_r    <= cfg_h_i;
          mode   <= (cfg_mode_i > 3'd4) ? 3'd0 : cfg_mode_i;
          bcnt   <= '0;
          rcnt   <= '0;
          state  <= TYPE;
        end
        TYPE: if (out_free) begin
          val_q <= 1'b1;
          dat_q <= {5'b0, mode};
          lst_q <= 1'b0;
          state <= DATA;
        end
        DATA: if (acc) begin
          val_q   <= 1'b1;
          dat_q   <= filt;
          lst_q   <= last_b;
          a_sr[0] <= x;
          c_sr[0] <= b;
          for (int i = 1; i < BPP; i++) begin
            a_sr[i] <= a_sr[i-1];
            c_sr[i] <= c_sr[i-1];
          end
          if (last_b) begin
            bcnt  <= '0;
            rcnt  <= rcnt + H_WD'(1);
            state <= (rcnt == h_r - H_WD'(1)) ? DONE : TYPE;
          end else begin
            bcnt  <= bcnt + CW'(1);
          end
        end
        DONE: if (out_free) begin
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
